proc_clk_gate: RTL and testbench
================================

Name: proc_clk_gate

Overview:
- Sits directly downstream of the processor clock divider in the board-clock domain.
- Samples the divider's square-wave output on the board clock and converts each rising edge into a one-cycle clock-enable pulse for the MIPS core.
- Pulses are gated by run / single-step / halt control, so the core can be free-run, stepped by a push button, or frozen on a halt request.
- Keeps a count of issued enables for debug display.

Parameters:
- DEB_CYCLES, 4, number of consecutive board-clock cycles the synchronised step button must hold a new level before the level is accepted.
- CNT_W, 16, width of cycle_count.

Ports:
- clk  in  1  board clock, the same clock that drives the divider.
- reset_n  in  1  asynchronous, active-low reset.
- tick_in  in  1  divider output level; synchronous to clk.
- run_mode  in  1  level input; 1 = free-run, 0 = stepped/idle.
- step_btn  in  1  raw push button; asynchronous, bouncing.
- halt_req  in  1  level input from the core (halt/syscall decode).
- clear_halt  in  1  level input; releases the STOPPED state.
- proc_ce  out  1  registered one-cycle enable to the core.
- state  out  2  FSM state encoding.
- halted  out  1  high exactly when state is STOPPED.
- cycle_count  out  CNT_W  number of proc_ce pulses issued.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. Clock port is clk; reset port is reset_n.
- Reset values: proc_ce=0, state=IDLE, halted=0, cycle_count=0. Internal registers also reset: tick_q=0, synchroniser=0, debounce counter=0, stable=0.
- Edge detect: tick_q registers tick_in. Define tick_rise = tick_in & ~tick_q.
  - The first tick_in high after reset counts as a rise.
- Step path:
  - 2-flop synchroniser on step_btn.
  - Debounce counter: clears whenever the synced level equals stable; otherwise increments.
  - When the counter reaches DEB_CYCLES-1 while the levels still differ, stable takes the synced level and the counter clears.
  - step_pulse = one cycle on each 0->1 update of stable.
  - Fixed latency from a clean step_btn rise to step_pulse: 2 + DEB_CYCLES cycles.
- FSM state encodings: IDLE=0, RUN=1, STEP_WAIT=2, STOPPED=3.
- Priority order, evaluated each cycle:
  - halt_req in IDLE, RUN or STEP_WAIT -> STOPPED. It overrides everything else, including a coincident tick_rise.
  - STOPPED: clear_halt=1 and halt_req=0 -> IDLE. Otherwise remain in STOPPED.
  - IDLE: run_mode=1 -> RUN. Else step_pulse -> STEP_WAIT.
  - RUN: run_mode=0 -> IDLE.
  - STEP_WAIT: tick_rise -> IDLE. run_mode is ignored in this state.
- proc_ce (registered) is set next cycle when tick_rise is high and either:
  - state==RUN, run_mode==1 and halt_req==0; or
  - state==STEP_WAIT and halt_req==0.
  - Otherwise proc_ce is 0. Latency is 1 cycle from tick_rise.
- In RUN with run_mode falling in the same cycle as tick_rise: no pulse is issued.
- step_pulse arriving outside IDLE is discarded; it is not queued.
  - A step arriving in the same cycle IDLE->RUN is taken is also discarded.
- cycle_count increments by 1 in each cycle where proc_ce==1 and wraps modulo 2^CNT_W.
- Reset asserted mid-operation: all state clears immediately. An in-flight proc_ce is dropped and a pending step is lost.

Decomposition:
- Shared package proc_clk_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_STEP_WAIT, ST_STOPPED;
  - default DEB_CYCLES.
- One sub-module: btn_debounce (synchroniser, debounce counter, rising-pulse output), parameterised by DEB_CYCLES. It is reused for future board buttons.
- FSM, edge detect and counter stay in proc_clk_gate.

Test Plan:
- Free-run, 6-cycle tick period: drive tick_in as 3 low / 3 high, run_mode=1 for 60 cycles -> 10 proc_ce pulses, each exactly 1 cycle wide, each 1 cycle after tick_in rises; cycle_count=10.
- Single step: run_mode=0, step_btn held high 20 cycles with DEB_CYCLES=4 -> exactly one step_pulse 6 cycles after the press, STEP_WAIT, one proc_ce after the next tick rise, back to IDLE; cycle_count +1.
- Bounce: step_btn toggles every 2 cycles for 12 cycles, then settles low -> no step_pulse, no proc_ce, state stays IDLE.
- Halt vs tick: in RUN, assert halt_req in the same cycle as tick_rise -> no proc_ce; state=STOPPED; halted=1. clear_halt with halt_req=0 -> IDLE next cycle. clear_halt with halt_req=1 -> stays STOPPED.
- Wrap: CNT_W=4, run 17 ticks -> cycle_count reads 1.
- Async reset: assert reset_n low mid-RUN in the cycle a proc_ce is due -> proc_ce=0, state=IDLE, cycle_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_clk_gate_pkg.sv
// proc_clk_pkg: shared definitions for the processor clock-gate slice.
//   clk_state_e    - gate FSM state encoding (ST_IDLE..ST_STOPPED)
//   DEB_CYCLES_DEF - default debounce hold time in board-clock cycles
package proc_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_STOPPED   = 2'd3
    } clk_state_e;

    localparam int unsigned DEB_CYCLES_DEF = 4;

endpackage

// File: rtl/proc_clk_gate_debounce.sv
// btn_debounce: synchronises a raw, bouncing push button and emits a
// one-cycle pulse each time the debounced level rises.
//   clk      in  board clock
//   reset_n  in  asynchronous active-low reset
//   btn      in  raw button (asynchronous)
//   pulse    out one-cycle pulse on each accepted 0->1 transition
// Latency from a clean button rise to pulse is 2 + DEB_CYCLES cycles.
module btn_debounce
    import proc_clk_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            pulse  <= 1'b0;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level has differed for DEB_CYCLES consecutive samples.
                stable <= sync_q[1];
                cnt    <= '0;
                pulse  <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_clk_gate.sv
// proc_clk_gate: turns rising edges of the processor clock divider output
// into one-cycle clock enables for the core, gated by run / step / halt.
//   clk          in  board clock (also drives the divider)
//   reset_n      in  asynchronous active-low reset
//   tick_in      in  divider output level, synchronous to clk
//   run_mode     in  1 = free-run, 0 = stepped/idle
//   step_btn     in  raw single-step push button
//   halt_req     in  halt request from the core
//   clear_halt   in  releases the STOPPED state
//   proc_ce      out registered one-cycle enable to the core
//   state        out FSM state encoding
//   halted       out high while in STOPPED
//   cycle_count  out number of proc_ce pulses issued (wraps)
module proc_clk_gate
    import proc_clk_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             clear_halt,
    output logic             proc_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    clk_state_e cur_state;
    clk_state_e nxt_state;
    logic       tick_q;
    logic       tick_rise;
    logic       step_pulse;
    logic       ce_nxt;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (step_btn),
        .pulse   (step_pulse)
    );

    // tick_q resets low, so a divider already high after reset counts as a rise.
    assign tick_rise = tick_in & ~tick_q;

    always_comb begin
        nxt_state = cur_state;
        ce_nxt    = 1'b0;
        case (cur_state)
            ST_STOPPED: begin
                if (clear_halt && !halt_req) begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (halt_req) begin
                    nxt_state = ST_STOPPED;
                end else if (run_mode) begin
                    nxt_state = ST_RUN;
                end else if (step_pulse) begin
                    nxt_state = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    nxt_state = ST_STOPPED;
                end else if (!run_mode) begin
                    nxt_state = ST_IDLE;
                end else begin
                    ce_nxt = tick_rise;
                end
            end
            ST_STEP_WAIT: begin
                if (halt_req) begin
                    nxt_state = ST_STOPPED;
                end else if (tick_rise) begin
                    nxt_state = ST_IDLE;
                    ce_nxt    = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= ST_IDLE;
            tick_q      <= 1'b0;
            proc_ce     <= 1'b0;
            cycle_count <= '0;
        end else begin
            cur_state <= nxt_state;
            tick_q    <= tick_in;
            proc_ce   <= ce_nxt;
            if (proc_ce) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == ST_STOPPED);

endmodule

// File: tb/tb_proc_clk_gate.sv
module tb_proc_clk_gate;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    logic          clk;
    logic          reset_n;
    logic          tick_in;
    logic          run_mode;
    logic          step_btn;
    logic          halt_req;
    logic          clear_halt;
    logic          proc_ce;
    logic [1:0]    state;
    logic          halted;
    logic [CW-1:0] cycle_count;

    int errors = 0;
    int checks = 0;
    int ce_seen = 0;

    // Reference model state (spec-level: run lengths and plain integers)
    int m_tick_prev, m_s1, m_s2, m_stable, m_diff_run, m_step;
    int m_state, m_ce, m_cnt;

    proc_clk_gate #(
        .DEB_CYCLES(DEB),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_in     (tick_in),
        .run_mode    (run_mode),
        .step_btn    (step_btn),
        .halt_req    (halt_req),
        .clear_halt  (clear_halt),
        .proc_ce     (proc_ce),
        .state       (state),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tick_prev = 0; m_s1 = 0; m_s2 = 0; m_stable = 0; m_diff_run = 0;
        m_step = 0; m_state = 0; m_ce = 0; m_cnt = 0;
    endtask

    // One board-clock step of the reference, using the inputs held over the edge.
    task automatic model_step();
        int rise, ns, nce, np;
        rise = (tick_in && !m_tick_prev) ? 1 : 0;
        ns = m_state;
        if (m_state == 3) begin
            if (clear_halt && !halt_req) ns = 0;
        end else if (halt_req) begin
            ns = 3;
        end else if (m_state == 0) begin
            if (run_mode) ns = 1;
            else if (m_step != 0) ns = 2;
        end else if (m_state == 1) begin
            if (!run_mode) ns = 0;
        end else begin
            if (rise != 0) ns = 0;
        end
        nce = (rise != 0 && !halt_req && ((m_state == 1 && run_mode) || m_state == 2)) ? 1 : 0;
        m_cnt = (m_cnt + m_ce) % CMOD;
        // Accept a new synced level after DEB consecutive differing samples.
        np = 0;
        if (m_s2 != m_stable) begin
            m_diff_run++;
            if (m_diff_run == DEB) begin
                np = m_s2;
                m_stable = m_s2;
                m_diff_run = 0;
            end
        end else begin
            m_diff_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = step_btn ? 1 : 0;
        m_tick_prev = tick_in ? 1 : 0;
        m_state = ns;
        m_ce = nce;
        m_step = np;
    endtask

    // Starts and ends on a falling edge; inputs must be set before the call.
    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (proc_ce === 1'b1) ce_seen++;
        check_eq("proc_ce", proc_ce, m_ce);
        check_eq("state", state, m_state);
        check_eq("halted", halted, (m_state == 3) ? 1 : 0);
        check_eq("cycle_count", cycle_count, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tick_in = 1'b0; run_mode = 1'b0; step_btn = 1'b0;
        halt_req = 1'b0; clear_halt = 1'b0;
        model_reset();
        #1;
        check_eq("rst_proc_ce", proc_ce, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_count", cycle_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ce_seen = 0;
    endtask

    initial begin
        reset_n = 1'b1;
        tick_in = 1'b0; run_mode = 1'b0; step_btn = 1'b0;
        halt_req = 1'b0; clear_halt = 1'b0;
        model_reset();

        // Free run, 3 low / 3 high divider
        do_reset();
        run_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick_in = ((i % 6) >= 3);
            run_cycle();
        end
        check_eq("freerun_pulses", ce_seen, 10);
        check_eq("freerun_count", cycle_count, 10);

        // Single step
        do_reset();
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            run_cycle();
            if (i == 6) check_eq("step_before", state, 0);
            if (i == 7) check_eq("step_wait", state, 2);
        end
        step_btn = 1'b0;
        tick_in = 1'b1;
        run_cycle();
        check_eq("step_ce", proc_ce, 1);
        check_eq("step_idle", state, 0);
        tick_in = 1'b0;
        repeat (8) run_cycle();
        check_eq("step_pulses", ce_seen, 1);
        check_eq("step_count", cycle_count, 1);

        // Bouncing button
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step_btn = ((i / 2) % 2 == 0);
            run_cycle();
        end
        step_btn = 1'b0;
        repeat (20) run_cycle();
        check_eq("bounce_pulses", ce_seen, 0);
        check_eq("bounce_state", state, 0);

        // Halt coinciding with a tick rise
        do_reset();
        run_mode = 1'b1;
        repeat (3) run_cycle();
        check_eq("halt_pre_run", state, 1);
        tick_in = 1'b1; halt_req = 1'b1;
        run_cycle();
        check_eq("halt_no_ce", proc_ce, 0);
        check_eq("halt_state", state, 3);
        check_eq("halt_flag", halted, 1);
        tick_in = 1'b0; clear_halt = 1'b1;
        run_cycle();
        check_eq("halt_hold", state, 3);
        halt_req = 1'b0;
        run_cycle();
        check_eq("halt_release", state, 0);
        clear_halt = 1'b0;
        run_mode = 1'b0;
        repeat (2) run_cycle();

        // Counter wrap at CNT_W=4
        do_reset();
        run_mode = 1'b1;
        for (int i = 0; i < 102; i++) begin
            tick_in = ((i % 6) >= 3);
            run_cycle();
        end
        check_eq("wrap_pulses", ce_seen, 17);
        check_eq("wrap_count", cycle_count, 1);

        // Randomised operation
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            if ($urandom_range(0, 49) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 11) == 0) step_btn = ~step_btn;
            halt_req   = ($urandom_range(0, 59) == 0);
            clear_halt = ($urandom_range(0, 9) == 0);
            run_cycle();
        end

        // Asynchronous reset while a proc_ce is showing
        do_reset();
        run_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick_in = ((i % 6) >= 3);
            run_cycle();
        end
        begin
            int guard = 0;
            int k = 40;
            while (m_ce == 0 && guard < 12) begin
                tick_in = ((k % 6) >= 3);
                run_cycle();
                k++;
                guard++;
            end
            check_eq("areset_ce_due", m_ce, 1);
        end
        reset_n = 1'b0;
        #1;
        check_eq("areset_ce", proc_ce, 0);
        check_eq("areset_state", state, 0);
        check_eq("areset_count", cycle_count, 0);
        check_eq("areset_halted", halted, 0);
        model_reset();
        tick_in = 1'b0; run_mode = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) run_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
